// File: rtl/pal_bus_pkg.sv
// pal_bus_pkg
// Shared definitions for the PAL output-register bus: FSM state encoding for
// the board-side reader and the default bus geometry / timing values that the
// register-side design also uses.
package pal_bus_pkg;

    // Reader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CAP     = 3'd2,
        ST_CMP     = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Defaults shared with the register side.
    localparam int PAL_WIDTH     = 8;
    localparam int PAL_TURN      = 2;
    localparam int PAL_HOLD      = 1;
    localparam int PAL_MAX_RETRY = 3;

    // Width of a counter that must hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pal_bus_reader.sv
// pal_bus_reader
// Board-side initiator for the 8-bit PAL output register. Drives the PAL's
// active-low output enable, waits for the driver to turn on, samples the bus
// and only accepts a byte once two consecutive samples agree. Accepted bytes
// are offered to on-chip logic over a valid/ready handshake.
//
// Ports
//   clk       clock, all state changes on posedge
//   rst_n     synchronous active-low reset
//   req       start a read (looked at only in IDLE, ignored while valid = 1)
//   busy      high whenever the FSM is not IDLE
//   oe_n      registered output enable to the PAL, active low
//   bus_in    tristate bus as seen at the pins
//   data_out  last successfully captured byte
//   valid     data_out holds an unconsumed byte
//   ready     consumer takes data_out on valid & ready
//   err       one-cycle pulse when a read fails the stability check
module pal_bus_reader
    import pal_bus_pkg::*;
#(
    parameter int WIDTH     = PAL_WIDTH,
    parameter int TURN      = PAL_TURN,
    parameter int HOLD      = PAL_HOLD,
    parameter int MAX_RETRY = PAL_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             busy,
    output logic             oe_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             err
);

    localparam int TW = cnt_w(TURN);
    localparam int RW = cnt_w(MAX_RETRY);
    localparam int HW = cnt_w(HOLD);

    state_t           state_q, state_d;
    logic [TW-1:0]    turn_cnt;
    logic [RW-1:0]    retry_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] s0_q;
    logic             oe_n_q, valid_q, err_q;
    logic [WIDTH-1:0] data_q;

    // Control decoded from the current state.
    logic oe_n_d, s0_ld, data_ld, err_d, retry_inc;

    logic start, turn_last, retry_last, hold_last, match;

    // A read starts only on the pre-edge valid, so a same-edge consume does
    // not let a req through until the following edge.
    assign start      = req && !valid_q;
    assign turn_last  = (turn_cnt == TW'(TURN - 1));
    assign retry_last = (retry_cnt == RW'(MAX_RETRY));
    assign hold_last  = (hold_cnt == HW'(HOLD - 1));
    assign match      = (bus_in == s0_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_DRIVE;
            ST_DRIVE:   if (turn_last) state_d = ST_CAP;
            ST_CAP:     state_d = ST_CMP;
            ST_CMP:     if (match || retry_last) state_d = ST_RELEASE;
            ST_RELEASE: if (hold_last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs / datapath control. oe_n_d is the value oe_n takes after this
    // edge, so the pin changes on the same edge as the state transition.
    always_comb begin
        oe_n_d    = 1'b1;
        s0_ld     = 1'b0;
        data_ld   = 1'b0;
        err_d     = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            ST_IDLE:  oe_n_d = !start;
            ST_DRIVE: oe_n_d = 1'b0;
            ST_CAP: begin
                oe_n_d = 1'b0;
                s0_ld  = 1'b1;
            end
            ST_CMP: begin
                if (match) begin
                    data_ld = 1'b1;
                end else if (!retry_last) begin
                    // Re-sample: the newest value becomes the reference.
                    oe_n_d    = 1'b0;
                    s0_ld     = 1'b1;
                    retry_inc = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: oe_n_d = 1'b1;
        endcase
    end

    // Counters, capture and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turn_cnt  <= '0;
            retry_cnt <= '0;
            hold_cnt  <= '0;
            s0_q      <= '0;
            oe_n_q    <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            oe_n_q <= oe_n_d;
            err_q  <= err_d;

            // Each counter stops at its exit value because the state leaves
            // before it could count further.
            if (state_q == ST_IDLE) begin
                turn_cnt  <= '0;
                retry_cnt <= '0;
            end else begin
                if (state_q == ST_DRIVE && !turn_last) turn_cnt <= turn_cnt + 1'b1;
                if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
            end

            if (state_q != ST_RELEASE) hold_cnt <= '0;
            else if (!hold_last)       hold_cnt <= hold_cnt + 1'b1;

            if (s0_ld) s0_q <= bus_in;

            // Success only happens with valid = 0, so set and clear never collide.
            if (data_ld) begin
                data_q  <= s0_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign oe_n     = oe_n_q;
    assign valid    = valid_q;
    assign data_out = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pal_bus_reader.sv
module tb_pal_bus_reader;

    logic       clk = 1'b0;
    logic       rst_n, req, ready;
    logic       busy, oe_n, valid, err;
    logic [7:0] bus_in, bus_drv, data_out;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] sb[$];

    pal_bus_reader #(.WIDTH(8), .TURN(2), .HOLD(1), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .oe_n(oe_n),
        .bus_in(bus_in), .data_out(data_out), .valid(valid), .ready(ready),
        .err(err)
    );

    always #5 clk = ~clk;

    // Register PAL model: drives the bus only while enabled.
    assign bus_in = oe_n ? 8'h00 : bus_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every byte handed over must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            nchk++;
            assert (sb.size() > 0) else begin
                nerr++;
                $error("FAIL sb_empty: observed handover of %0h expected none", data_out);
            end
            if (sb.size() > 0) begin
                logic [7:0] e;
                e = sb.pop_front();
                nchk++;
                assert (data_out === e) else begin
                    nerr++;
                    $error("FAIL sb_data: observed %0h expected %0h", data_out, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = 1'b1; ready = 1'b0; bus_drv = 8'h00;

        // Reset with req held high
        repeat (3) tick();
        chk("rst_oe_n", oe_n, 1);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; req = 1'b0;
        repeat (2) tick();
        chk("idle_busy", busy, 0);
        chk("idle_oe_n", oe_n, 1);

        // Basic read
        bus_drv = 8'hA5; req = 1'b1; sb.push_back(8'hA5);
        tick();                         // edge 0
        req = 1'b0;
        chk("basic_busy_e0", busy, 1);
        for (int e = 0; e < 4; e++) begin
            chk("basic_oe_low", oe_n, 0);
            if (e < 3) tick();
        end
        tick();                         // edge 4
        chk("basic_oe_high_e4", oe_n, 1);
        chk("basic_valid_e4", valid, 1);
        chk("basic_data_e4", data_out, 8'hA5);
        chk("basic_busy_e4", busy, 1);
        tick();                         // edge 5
        chk("basic_busy_e5", busy, 0);
        chk("basic_valid_e5", valid, 1);
        ready = 1'b1;
        tick();                         // edge 6
        chk("basic_valid_e6", valid, 0);
        ready = 1'b0;
        tick();

        // Backpressure: req held, byte not consumed
        bus_drv = 8'hA5; req = 1'b1; sb.push_back(8'hA5);
        tick();                         // edge 0
        repeat (4) tick();              // edge 4
        chk("bp_valid_e4", valid, 1);
        bus_drv = 8'h5A;
        tick();                         // edge 5
        for (int e = 6; e <= 9; e++) begin
            tick();
            chk("bp_no_drive_busy", busy, 0);
            chk("bp_no_drive_oe", oe_n, 1);
            chk("bp_data_hold", data_out, 8'hA5);
        end
        ready = 1'b1;
        tick();                         // edge 10: consume, req not yet taken
        chk("bp_valid_e10", valid, 0);
        chk("bp_busy_e10", busy, 0);
        ready = 1'b0; sb.push_back(8'h5A);
        tick();                         // edge 11: new read starts
        req = 1'b0;
        chk("bp_busy_e11", busy, 1);
        chk("bp_oe_e11", oe_n, 0);
        repeat (4) tick();              // edge 15
        chk("bp2_valid", valid, 1);
        chk("bp2_data", data_out, 8'h5A);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();

        // Glitch retry: 3C at CAP, then FF, FF
        bus_drv = 8'h3C; req = 1'b1; sb.push_back(8'hFF);
        tick();                         // edge 0
        req = 1'b0;
        repeat (3) tick();              // edge 3: s0 = 3C
        bus_drv = 8'hFF;
        tick();                         // edge 4: mismatch, one retry
        chk("gl_valid_e4", valid, 0);
        chk("gl_oe_e4", oe_n, 0);
        tick();                         // edge 5
        chk("gl_valid_e5", valid, 1);
        chk("gl_data_e5", data_out, 8'hFF);
        chk("gl_err_e5", err, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();

        // Stability failure: bus toggles every cycle
        req = 1'b1; bus_drv = 8'h00;
        tick();                         // edge 0
        req = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            bus_drv = (e % 2) ? 8'hFF : 8'h00;
            tick();
            if (e < 7) chk("sf_no_err", err, 0);
        end
        chk("sf_err_e7", err, 1);
        chk("sf_oe_e7", oe_n, 1);
        chk("sf_valid_e7", valid, 0);
        chk("sf_data_e7", data_out, 8'hFF);
        tick();                         // edge 8
        chk("sf_err_e8", err, 0);
        tick();
        chk("sf_idle", busy, 0);

        // Reset mid-read
        bus_drv = 8'h77; req = 1'b1;
        tick();                         // edge 0
        req = 1'b0;
        tick();                         // edge 1
        rst_n = 1'b0;
        tick();                         // edge 2
        chk("mr_oe", oe_n, 1);
        chk("mr_busy", busy, 0);
        chk("mr_data", data_out, 8'h00);
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk("mr_no_valid", valid, 0);
            chk("mr_no_err", err, 0);
        end

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
